// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/busy/done handshake, iterative 1-bit/cycle shifts and Z/N/C flags.
// Define ALU_SEQ_MUL_EN to add opcode 1100, a WIDTH-cycle shift-add unsigned multiplier.
module alu_seq #(
    parameter int WIDTH   = 24,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A_bus,
    input  logic [WIDTH-1:0] B_bus,
    input  logic [3:0]       operation,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C_bus,
    output logic             Z_flag,
    output logic             N_flag,
    output logic             C_flag
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [3:0] OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_PASSA = 4'b0011, OP_PASSB = 4'b0100,
                           OP_INC = 4'b0101, OP_DEC = 4'b0110, OP_SHL = 4'b0111, OP_SHR = 4'b1000,
                           OP_CLR = 4'b1011, OP_MUL = 4'b1100;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] a_r, b_r, sh, sh_nx, res;
    logic [3:0] op_r;
    logic [CW-1:0] cnt, cnt0;
    logic [SHAMT_W-1:0] k;
    logic cy_nx, rc, upd, kz, shl;
`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] prod, prod_nx;
    logic [WIDTH:0] psum;
    // one multiplier bit per cycle: add A into the high half, then shift the whole product right
    always_comb begin
        psum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_r} : '0);
        prod_nx = {psum, prod[WIDTH-1:1]};
    end
`endif
    assign k   = B_bus[SHAMT_W-1:0];
    assign kz  = b_r[SHAMT_W-1:0] == '0;
    assign shl = op_r == OP_SHL;
    always_comb begin
        cnt0 = '0;
        if (operation == OP_SHL || operation == OP_SHR)
            cnt0 = (k == '0) ? '0 : (int'(k) >= WIDTH) ? CW'(WIDTH - 1) : CW'(k - 1'b1);
`ifdef ALU_SEQ_MUL_EN
        if (operation == OP_MUL) cnt0 = CW'(WIDTH - 1);
`endif
    end
    always_comb begin
        sh_nx = shl ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
        cy_nx = shl ? sh[WIDTH-1] : sh[0];
        rc    = 1'b0;
        res   = C_bus;
        upd   = 1'b1;
        case (op_r)
            OP_ADD:   {rc, res} = {1'b0, a_r} + {1'b0, b_r};
            OP_SUB:   {rc, res} = {1'b0, a_r} - {1'b0, b_r};
            OP_PASSA: res = a_r;
            OP_PASSB: res = b_r;
            OP_INC:   {rc, res} = {1'b0, a_r} + (WIDTH+1)'(1);
            OP_DEC:   {rc, res} = {1'b0, a_r} - (WIDTH+1)'(1);
            OP_SHL, OP_SHR: begin
                res = kz ? a_r : sh_nx;
                rc  = !kz && cy_nx;
            end
            OP_CLR:   res = '0;
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                res = prod_nx[WIDTH-1:0];
                rc  = |prod_nx[2*WIDTH-1:WIDTH];
            end
`endif
            default:  upd = 1'b0;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            C_bus  <= '0;
            Z_flag <= 1'b0;
            N_flag <= 1'b0;
            C_flag <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= '0;
            sh     <= '0;
            cnt    <= '0;
`ifdef ALU_SEQ_MUL_EN
            prod   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        state <= EXEC;
                        busy  <= 1'b1;
                        a_r   <= A_bus;
                        b_r   <= B_bus;
                        op_r  <= operation;
                        sh    <= A_bus;
                        cnt   <= cnt0;
`ifdef ALU_SEQ_MUL_EN
                        prod  <= {{WIDTH{1'b0}}, B_bus};
`endif
                    end
                end
                EXEC: begin
                    sh  <= sh_nx;
                    cnt <= cnt - 1'b1;
`ifdef ALU_SEQ_MUL_EN
                    prod <= prod_nx;
`endif
                    if (cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (upd) begin
                            C_bus  <= res;
                            Z_flag <= res == '0;
                            N_flag <= res[WIDTH-1];
                            C_flag <= rc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
    localparam int W = 24;
    logic clk = 0, rst_n = 0, start = 0;
    logic [W-1:0] A_bus = 0, B_bus = 0;
    logic [3:0] operation = 0;
    logic busy, done, Z_flag, N_flag, C_flag;
    logic [W-1:0] C_bus;
    int n_cmp = 0, n_err = 0;
    logic [W-1:0] exp_c = 0;
    logic exp_z = 0, exp_n = 0, exp_cf = 0;
    int exp_lat = 1;

    alu_seq #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .A_bus(A_bus), .B_bus(B_bus), .operation(operation),
        .start(start), .busy(busy), .done(done), .C_bus(C_bus),
        .Z_flag(Z_flag), .N_flag(N_flag), .C_flag(C_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected outcome straight from the opcode table; undefined opcodes leave the state alone
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        longint unsigned x = 64'(a), y = 64'(b), r = 0;
        int kk = int'(b[4:0]);
        bit c = 0, def = 1;
        if (kk > W) kk = W;
        exp_lat = 1;
        case (op)
            4'd1:  begin r = x + y; c = r[W]; end
            4'd2:  begin r = x - y; c = x < y; end
            4'd3:  r = x;
            4'd4:  r = y;
            4'd5:  begin r = x + 1; c = r[W]; end
            4'd6:  begin r = x - 1; c = x == 0; end
            4'd7:  begin r = x << kk; c = (kk > 0) ? x[W-kk] : 1'b0; exp_lat = (kk > 0) ? kk : 1; end
            4'd8:  begin r = x >> kk; c = (kk > 0) ? x[kk-1] : 1'b0; exp_lat = (kk > 0) ? kk : 1; end
            4'd11: r = 0;
`ifdef ALU_SEQ_MUL_EN
            4'd12: begin r = x * y; c = (r >> W) != 0; exp_lat = W; end
`endif
            default: def = 0;
        endcase
        if (def) begin
            exp_c  = r[W-1:0];
            exp_z  = exp_c == 0;
            exp_n  = exp_c[W-1];
            exp_cf = c;
        end
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                          input bit poke, input bit skip_c);
        int n = 0;
        A_bus = a; B_bus = b; operation = op; start = 1;
        model(a, b, op);
        @(posedge clk); #1;
        start = 0; A_bus = $urandom; B_bus = $urandom; operation = 4'($urandom);
        chk("busy_after_accept", 32'(busy), 1);
        do begin
            start = poke && n == 3;
            @(posedge clk); #1;
            n++;
        end while (!done && n < 100);
        start = 0;
        chk("latency", n, exp_lat);
        chk("c_bus", 32'(C_bus), 32'(exp_c));
        chk("z_flag", 32'(Z_flag), 32'(exp_z));
        chk("n_flag", 32'(N_flag), 32'(exp_n));
        if (!skip_c) chk("c_flag", 32'(C_flag), 32'(exp_cf));
        chk("busy_at_done", 32'(busy), 0);
    endtask

    task automatic idle_check();
        @(posedge clk); #1;
        chk("single_done", 32'(done), 0);
    endtask

    logic [3:0] ops [16] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                             4'd11, 4'd12, 4'd0, 4'd9, 4'd10, 4'd13, 4'd14, 4'd15};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_c_bus", 32'(C_bus), 0);
        chk("rst_flags", {29'd0, Z_flag, N_flag, C_flag}, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        run_op(24'hFFFFFF, 24'h000001, 4'd1, 0, 0);
        idle_check();
        run_op(24'd5, 24'd7, 4'd2, 0, 0);
        run_op(24'd7, 24'd7, 4'd2, 0, 0);
        run_op(24'h000001, 24'd9, 4'd7, 0, 0);
        run_op(24'h800000, 24'd30, 4'd8, 0, 1);
        idle_check();
        run_op(24'h123456, 24'd8, 4'd7, 1, 0);
        repeat (3) idle_check();

        A_bus = 24'h00ABCD; B_bus = 24'd20; operation = 4'd7; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (5) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_c_bus", 32'(C_bus), 0);
        chk("midrst_flags", {28'd0, done, Z_flag, N_flag, C_flag}, 0);
        exp_c = 0; exp_z = 0; exp_n = 0; exp_cf = 0;
        @(negedge clk) rst_n = 1;
        begin
            bit seen = 0;
            repeat (25) begin
                @(posedge clk); #1;
                if (done) seen = 1;
            end
            chk("no_done_after_abort", 32'(seen), 0);
        end

        run_op(24'h001000, 24'h001000, 4'd12, 0, 0);
        idle_check();
        run_op(24'h000000, 24'h0, 4'd6, 0, 0);
        run_op(24'hFFFFFF, 24'h0, 4'd5, 0, 0);
        run_op(24'h5A5A5A, 24'h0, 4'd0, 0, 0);
        run_op(24'h800001, 24'h20, 4'd7, 0, 0);
        run_op(24'h800001, 24'd1, 4'd8, 0, 0);
        run_op(24'h800001, 24'd24, 4'd7, 0, 0);
        run_op(24'h654321, 24'h111111, 4'd11, 0, 0);
        run_op(24'h654321, 24'h111111, 4'd3, 0, 0);
        run_op(24'h654321, 24'h811111, 4'd4, 0, 0);

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a, b;
            logic [3:0] op;
            a = W'($urandom);
            b = W'($urandom);
            op = ops[$urandom_range(0, 15)];
            if (op == 4'd7 || op == 4'd8) b[4:0] = 5'($urandom_range(0, W));
            if ($urandom_range(0, 2) == 0) idle_check();
            run_op(a, b, op, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
